uart_hamming_rx: RTL

UART_HAMMING_RX -- requirements
Module: uart_hamming_rx

---
 rtl/uart_hamming_rx.sv | 89 ++++++++
 1 files changed

// File: rtl/uart_hamming_rx.sv
// uart_hamming_rx: UART byte receiver with Hamming(7,4) single-error correction
module uart_hamming_rx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [3:0] data_out,
   output logic       data_valid,
   output logic [2:0] syndrome,
   output logic       corrected,
   output logic       pad_err,
   output logic       frame_err,
   output logic       rx_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE, WAIT_IDLE} state_t;
   state_t        state, state_nx;
   logic          rx_m, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [2:0]    syn;
   logic [3:0]    data_fix;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (!rx_s) state_nx = START;
         START:     if (cnt == HALF) state_nx = rx_s ? IDLE : DATA;
         DATA:      if (cnt == LAST && bit_idx == 3'd7) state_nx = STOP;
         STOP:      if (cnt == LAST) state_nx = rx_s ? DECODE : WAIT_IDLE;
         DECODE:    state_nx = IDLE;
         WAIT_IDLE: if (rx_s) state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end
   // counter restarts on every transition and on each data-bit boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= (state_nx != state || state == IDLE || (state == DATA && cnt == LAST)) ? '0 : cnt + CW'(1);
         bit_idx <= (state != DATA) ? 3'd0 : (cnt == LAST) ? bit_idx + 3'd1 : bit_idx;
         if (state == DATA && cnt == LAST)
            shreg <= {rx_s, shreg[7:1]};
      end
   end
   assign syn = {shreg[3] ^ shreg[4] ^ shreg[5] ^ shreg[6],
                 shreg[1] ^ shreg[2] ^ shreg[5] ^ shreg[6],
                 shreg[0] ^ shreg[2] ^ shreg[4] ^ shreg[6]};
   // only data positions matter after correction; parity flips are dropped
   assign data_fix = {shreg[6] ^ (syn == 3'd7), shreg[5] ^ (syn == 3'd6),
                      shreg[4] ^ (syn == 3'd5), shreg[2] ^ (syn == 3'd3)};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         syndrome   <= '0;
         corrected  <= 1'b0;
         pad_err    <= 1'b0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         data_valid <= state == DECODE;
         frame_err  <= state == STOP && cnt == LAST && !rx_s;
         if (state == DECODE) begin
            data_out  <= data_fix;
            syndrome  <= syn;
            corrected <= syn != 3'd0;
            pad_err   <= shreg[7];
         end
      end
   end
   assign rx_busy = state != IDLE;
endmodule
